ccx_emem_bridge: RTL and testbench
==================================

Name: ccx_emem_bridge

Overview:
- Sits directly downstream of the core complex external memory port (emem_*) and converts it to a decoupled external bus.
- The external bus has a valid/ready request channel and a separate valid-only response channel with arbitrary latency.
- Holds emem_gnt low until the external response is back, then grants and returns read data and error on the core-bus timing.
- A watchdog converts a hung external access into a bus error.

Parameters:
AW, 39, address width.
DW, 64, data width (strobe width DW/8).
TIMEOUT, 1024, max cycles spent in ISSUE+WAIT before abort; must be >= 2.

Ports:
g_clk  input  1  global clock.
g_reset  input  1  synchronous active-high reset.
emem_req  input  1  core request, held with fields stable until emem_gnt.
emem_addr  input  AW  request address.
emem_wen  input  1  write enable.
emem_strb  input  DW/8  write byte strobes.
emem_wdata  input  DW  write data.
emem_gnt  output  1  request accepted this cycle.
emem_err  output  1  response error, valid the cycle after gnt.
emem_rdata  output  DW  read data, valid the cycle after gnt.
ext_req_valid  output  1  external request valid.
ext_req_ready  input  1  external request accepted.
ext_req_addr  output  AW  registered copy of emem_addr.
ext_req_wen  output  1  registered copy of emem_wen.
ext_req_strb  output  DW/8  registered copy of emem_strb.
ext_req_wdata  output  DW  registered copy of emem_wdata.
ext_rsp_valid  input  1  external response valid (one cycle per request).
ext_rsp_err  input  1  external response error.
ext_rsp_rdata  input  DW  external response read data.
busy  output  1  state != IDLE.

Behaviour:
- One clock g_clk. Reset is synchronous and active-high on g_reset.
- Reset values:
  - state=IDLE.
  - All outputs 0.
  - Capture registers 0, timer 0.
  - Drop flag cleared.
- Core bus protocol:
  - A transfer is accepted when emem_req && emem_gnt.
  - emem_rdata and emem_err are valid exactly one cycle later.
  - Both hold their value until the next response is captured.
- IDLE:
  - emem_gnt=0.
  - If emem_req: capture addr/wen/strb/wdata, clear timer, go to ISSUE.
- ISSUE:
  - ext_req_valid=1; ext_req_* driven from the capture registers.
  - On ext_req_ready: go to WAIT; the timer keeps counting.
  - ext_rsp_valid in ISSUE is ignored.
- WAIT:
  - On ext_rsp_valid: latch rsp_err and rsp_rdata (rdata is latched for writes too), go to GRANT.
  - ext_rsp_valid is accepted no earlier than the cycle after ext_req_ready.
- GRANT:
  - emem_gnt=1 for exactly one cycle.
  - Next state is IDLE, or DRAIN if the drop flag is set.
  - The latched response appears on emem_rdata/emem_err in the following cycle.
- Timer:
  - Increments each cycle in ISSUE or WAIT, saturating.
  - If it reaches TIMEOUT-1 without the exit condition in that cycle: latch err=1, rdata=0, go to GRANT.
  - Timeout in ISSUE: ext_req_valid drops; no response is expected.
  - Timeout in WAIT: set the drop flag; one late response is still owed.
  - If the exit event and the timeout fall in the same cycle, the exit event wins.
- DRAIN:
  - busy=1; no new capture.
  - ext_rsp_valid is discarded, clears the drop flag, and the state goes to IDLE.
  - A second TIMEOUT without a response also clears the flag and goes to IDLE.
- Minimum latency: req in cycle 0 → ISSUE c1 (ready) → WAIT c2 (rsp) → GRANT c3 → data c4.
- Back-to-back: emem_req high in the cycle after GRANT is a new request, captured in IDLE.
- ext_rsp_valid outside WAIT/DRAIN: ignored, no state change.
- g_reset mid-transaction: returns to IDLE immediately and clears the drop flag. An outstanding external response arriving afterwards is ignored.
- emem_req may drop only after gnt. Changes to the emem fields after capture have no effect.

Test Plan:
- Read, zero wait: addr=0x1000_0008, ready in c1, rsp c2 with rdata=0xDEADBEEF_CAFEF00D, err=0 → gnt high c3 only; c4 rdata=0xDEADBEEF_CAFEF00D, err=0.
- Write with backpressure: wen=1, strb=0x0F, wdata=0x1122334455667788, ready held low 5 cycles → ext_req_* stable with valid high throughout; gnt exactly one cycle after the rsp cycle; err follows ext_rsp_err=1 → emem_err=1.
- Timeout in WAIT, TIMEOUT=16: no rsp → gnt at cycle 16 after the ISSUE entry, err=1, rdata=0. A late rsp (rdata=0xAA) arrives in DRAIN → discarded; busy falls; the next read returns its own data, not 0xAA.
- Timeout in ISSUE, TIMEOUT=16, ready never high → err=1 and ext_req_valid drops; state goes straight to IDLE with no DRAIN.
- Back-to-back reads A, B, with req held high after A's gnt → B captured the cycle after A's GRANT; responses arrive in order with correct data; no extra gnt pulses.
- g_reset asserted in WAIT → next cycle: all outputs 0, busy=0. A stray ext_rsp_valid afterwards produces no gnt.

Source files
------------

// File: rtl/ccx_emem_bridge.sv
// ccx_emem_bridge: core-complex external memory port to decoupled external bus.
// The core request is captured, issued on a valid/ready channel, and its
// response is collected from a valid-only channel of arbitrary latency. The
// core sees emem_gnt only once the response is in hand; rdata/err follow one
// cycle after gnt. A watchdog turns a hung access into a bus error and, if
// the request had already been accepted, swallows the late response.
//
// state | meaning
// IDLE  | waiting for emem_req; captures the request fields
// ISSUE | ext_req_valid high until ext_req_ready (or watchdog)
// WAIT  | request accepted, waiting for ext_rsp_valid (or watchdog)
// GRANT | one-cycle emem_gnt; response moves to emem_rdata/emem_err
// DRAIN | abandoned access still owes one response; discard it
module ccx_emem_bridge #(
  parameter int AW      = 39,
  parameter int DW      = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            emem_req,
  input  logic [AW-1:0]   emem_addr,
  input  logic            emem_wen,
  input  logic [DW/8-1:0] emem_strb,
  input  logic [DW-1:0]   emem_wdata,
  output logic            emem_gnt,
  output logic            emem_err,
  output logic [DW-1:0]   emem_rdata,
  output logic            ext_req_valid,
  input  logic            ext_req_ready,
  output logic [AW-1:0]   ext_req_addr,
  output logic            ext_req_wen,
  output logic [DW/8-1:0] ext_req_strb,
  output logic [DW-1:0]   ext_req_wdata,
  input  logic            ext_rsp_valid,
  input  logic            ext_rsp_err,
  input  logic [DW-1:0]   ext_rsp_rdata,
  output logic            busy
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TC = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    GRANT = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          drop;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          timer_tc;

  // Watchdog terminal count; the timer saturates here.
  assign timer_tc = (timer == TC);

  // Bridge sequencer with registered core-side and bus-side outputs.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state         <= IDLE;
      timer         <= '0;
      drop          <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_rdata     <= '0;
      emem_gnt      <= 1'b0;
      emem_err      <= 1'b0;
      emem_rdata    <= '0;
      ext_req_valid <= 1'b0;
      ext_req_addr  <= '0;
      ext_req_wen   <= 1'b0;
      ext_req_strb  <= '0;
      ext_req_wdata <= '0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (emem_req) begin
            ext_req_addr  <= emem_addr;
            ext_req_wen   <= emem_wen;
            ext_req_strb  <= emem_strb;
            ext_req_wdata <= emem_wdata;
            ext_req_valid <= 1'b1;
            timer         <= '0;
            busy          <= 1'b1;
            state         <= ISSUE;
          end
        end

        ISSUE: begin
          if (!timer_tc) timer <= timer + 1'b1;
          if (ext_req_ready) begin
            ext_req_valid <= 1'b0;
            state         <= WAIT;
          end else if (timer_tc) begin
            // Never accepted: nothing is owed, so no drain afterwards.
            ext_req_valid <= 1'b0;
            rsp_err       <= 1'b1;
            rsp_rdata     <= '0;
            emem_gnt      <= 1'b1;
            state         <= GRANT;
          end
        end

        WAIT: begin
          if (!timer_tc) timer <= timer + 1'b1;
          if (ext_rsp_valid) begin
            rsp_err   <= ext_rsp_err;
            rsp_rdata <= ext_rsp_rdata;
            emem_gnt  <= 1'b1;
            state     <= GRANT;
          end else if (timer_tc) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            drop      <= 1'b1;
            emem_gnt  <= 1'b1;
            state     <= GRANT;
          end
        end

        GRANT: begin
          emem_gnt   <= 1'b0;
          emem_rdata <= rsp_rdata;
          emem_err   <= rsp_err;
          if (drop) begin
            timer <= '0;
            state <= DRAIN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        DRAIN: begin
          if (ext_rsp_valid || timer_tc) begin
            drop  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          state         <= IDLE;
          emem_gnt      <= 1'b0;
          ext_req_valid <= 1'b0;
          drop          <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccx_emem_bridge.sv
// Testbench for ccx_emem_bridge: directed scenarios plus randomized traffic,
// with a response scoreboard drained by an independent monitor.
module tb_ccx_emem_bridge;

  localparam int AW = 39;
  localparam int DW = 64;
  localparam int TO = 16;

  logic            g_clk = 1'b0;
  logic            g_reset;
  logic            emem_req;
  logic [AW-1:0]   emem_addr;
  logic            emem_wen;
  logic [DW/8-1:0] emem_strb;
  logic [DW-1:0]   emem_wdata;
  logic            emem_gnt;
  logic            emem_err;
  logic [DW-1:0]   emem_rdata;
  logic            ext_req_valid;
  logic            ext_req_ready;
  logic [AW-1:0]   ext_req_addr;
  logic            ext_req_wen;
  logic [DW/8-1:0] ext_req_strb;
  logic [DW-1:0]   ext_req_wdata;
  logic            ext_rsp_valid;
  logic            ext_rsp_err;
  logic [DW-1:0]   ext_rsp_rdata;
  logic            busy;

  ccx_emem_bridge #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .emem_req(emem_req), .emem_addr(emem_addr), .emem_wen(emem_wen),
    .emem_strb(emem_strb), .emem_wdata(emem_wdata),
    .emem_gnt(emem_gnt), .emem_err(emem_err), .emem_rdata(emem_rdata),
    .ext_req_valid(ext_req_valid), .ext_req_ready(ext_req_ready),
    .ext_req_addr(ext_req_addr), .ext_req_wen(ext_req_wen),
    .ext_req_strb(ext_req_strb), .ext_req_wdata(ext_req_wdata),
    .ext_rsp_valid(ext_rsp_valid), .ext_rsp_err(ext_rsp_err),
    .ext_rsp_rdata(ext_rsp_rdata), .busy(busy)
  );

  always #5 g_clk = ~g_clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Response monitor: every gnt must match the oldest expected response.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge g_clk);
      if (emem_gnt === 1'b1) begin
        @(negedge g_clk);
        chk("gnt_width", 64'(emem_gnt), 64'd0);
        if (sbq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_gnt: got unexpected gnt, scoreboard empty (t=%0t)", $time);
        end else begin
          e = sbq.pop_front();
          chk("rsp_rdata", emem_rdata, e.rdata);
          chk("rsp_err", 64'(emem_err), 64'(e.err));
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge g_clk); #1;
      emem_req = 1'b0;
      ext_req_ready = 1'b0;
      ext_rsp_valid = 1'b0;
      @(negedge g_clk);
    end
  endtask

  // One core transfer. dr: cycles from ISSUE entry until ready is offered;
  // ds: cycles after the ready cycle's successor until the response.
  // Large values model a bus that never answers.
  task automatic txn(input logic [AW-1:0] a, input logic w, input logic [7:0] s,
                     input logic [DW-1:0] d, input int dr, input int ds,
                     input logic rerr, input logic [DW-1:0] rdat, input bit late);
    int   rpos, wait_lim, exit_pos, gpos, cnt;
    bit   issue_to, wait_to;
    exp_t e;
    // Window positions count from 0 at the first ISSUE cycle; the watchdog
    // fires at position TO-1, or on the first WAIT cycle if ready came later.
    rpos     = dr + 1 + ds;
    issue_to = (dr > TO - 1);
    wait_lim = (TO - 1 > dr + 1) ? TO - 1 : dr + 1;
    wait_to  = !issue_to && (rpos > wait_lim);
    exit_pos = issue_to ? TO - 1 : (wait_to ? wait_lim : rpos);
    e.err    = (issue_to || wait_to) ? 1'b1 : rerr;
    e.rdata  = (issue_to || wait_to) ? '0 : rdat;
    sbq.push_back(e);

    @(posedge g_clk); #1;
    emem_req = 1'b1; emem_addr = a; emem_wen = w; emem_strb = s; emem_wdata = d;
    gpos = -1;
    for (int p = 0; p < 60; p++) begin
      @(posedge g_clk); #1;
      if (p == 0) begin
        emem_addr  = AW'({$urandom, $urandom});
        emem_wen   = ~w;
        emem_strb  = ~s;
        emem_wdata = {$urandom, $urandom};
      end
      ext_req_ready = (p == dr) && (p <= exit_pos);
      ext_rsp_valid = !issue_to && (p == rpos) && (p <= exit_pos);
      ext_rsp_err   = rerr;
      ext_rsp_rdata = rdat;
      @(negedge g_clk);
      if (p <= dr && p <= TO - 1) chk("req_valid", 64'(ext_req_valid), 64'd1);
      if (p == 0 || p == dr) begin
        chk("req_addr", 64'(ext_req_addr), 64'(a));
        chk("req_wen", 64'(ext_req_wen), 64'(w));
        chk("req_strb", 64'(ext_req_strb), 64'(s));
        chk("req_wdata", ext_req_wdata, d);
      end
      if (issue_to && p == TO) chk("req_valid_drop", 64'(ext_req_valid), 64'd0);
      if (emem_gnt === 1'b1) begin
        gpos = p;
        break;
      end
    end
    chk("gnt_cycle", 64'(gpos), 64'(exit_pos + 1));

    if (wait_to) begin
      @(posedge g_clk); #1;
      emem_req = 1'b0;
      if (late) begin
        ext_rsp_valid = 1'b1;
        ext_rsp_err   = 1'b0;
        ext_rsp_rdata = 64'hAA;
        @(negedge g_clk);
        chk("drain_busy", 64'(busy), 64'd1);
        @(posedge g_clk); #1;
        ext_rsp_valid = 1'b0;
        @(negedge g_clk);
        chk("drain_done", 64'(busy), 64'd0);
      end else begin
        cnt = 0;
        @(negedge g_clk);
        for (int i = 0; i < 40 && busy === 1'b1; i++) begin
          cnt++;
          @(posedge g_clk); #1;
          @(negedge g_clk);
        end
        chk("drain_len", 64'(cnt), 64'(TO));
      end
    end
  endtask

  initial begin : stim
    logic [DW-1:0] rd;
    int dr, ds;
    g_reset = 1'b1;
    emem_req = 1'b0; emem_addr = '0; emem_wen = 1'b0; emem_strb = '0; emem_wdata = '0;
    ext_req_ready = 1'b0; ext_rsp_valid = 1'b0; ext_rsp_err = 1'b0; ext_rsp_rdata = '0;
    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    chk("rst_gnt", 64'(emem_gnt), 64'd0);
    chk("rst_rdata", emem_rdata, 64'd0);
    chk("rst_valid", 64'(ext_req_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge g_clk); #1;
    g_reset = 1'b0;

    // Zero-wait read.
    txn(39'h10000008, 1'b0, 8'h00, 64'd0, 0, 0, 1'b0, 64'hDEADBEEF_CAFEF00D, 1'b0);
    idle(1);
    // Write with 5 cycles of backpressure and an error response.
    txn(39'h00000040, 1'b1, 8'h0F, 64'h1122334455667788, 5, 1, 1'b1, 64'h0, 1'b0);
    idle(1);
    // WAIT timeout, late response drained, then a clean read.
    txn(39'h00000100, 1'b0, 8'h00, 64'd0, 0, 99, 1'b0, 64'h5, 1'b1);
    txn(39'h00000108, 1'b0, 8'h00, 64'd0, 1, 0, 1'b0, 64'h0123456789ABCDEF, 1'b0);
    idle(1);
    // WAIT timeout with no late response: second watchdog ends DRAIN.
    txn(39'h00000200, 1'b0, 8'h00, 64'd0, 2, 99, 1'b0, 64'h6, 1'b0);
    // ISSUE timeout: straight back to IDLE.
    txn(39'h00000300, 1'b1, 8'hFF, 64'hFFFF0000FFFF0000, 99, 0, 1'b0, 64'h7, 1'b0);
    idle(1);
    chk("issue_to_idle", 64'(busy), 64'd0);
    // Exit event and watchdog in the same cycle: exit wins.
    txn(39'h00000400, 1'b0, 8'h00, 64'd0, 13, 1, 1'b0, 64'h1111, 1'b0);
    txn(39'h00000408, 1'b0, 8'h00, 64'd0, 15, 0, 1'b0, 64'h2222, 1'b0);
    idle(1);
    // Back-to-back reads with emem_req held high.
    txn(39'h00000A00, 1'b0, 8'h00, 64'd0, 0, 0, 1'b0, 64'hA0A0A0A0A0A0A0A0, 1'b0);
    txn(39'h00000B00, 1'b0, 8'h00, 64'd0, 1, 2, 1'b0, 64'hB0B0B0B0B0B0B0B0, 1'b0);
    idle(1);

    // Reset asserted while waiting for the response.
    @(posedge g_clk); #1;
    emem_req = 1'b1; emem_addr = 39'h00000C00; emem_wen = 1'b1; emem_strb = 8'h3C;
    emem_wdata = 64'h0C0C0C0C0C0C0C0C;
    @(posedge g_clk); #1;
    ext_req_ready = 1'b1;
    @(posedge g_clk); #1;
    ext_req_ready = 1'b0;
    g_reset = 1'b1;
    @(negedge g_clk);
    chk("wait_busy", 64'(busy), 64'd1);
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    emem_req = 1'b0;
    @(negedge g_clk);
    chk("rst2_gnt", 64'(emem_gnt), 64'd0);
    chk("rst2_err", 64'(emem_err), 64'd0);
    chk("rst2_rdata", emem_rdata, 64'd0);
    chk("rst2_valid", 64'(ext_req_valid), 64'd0);
    chk("rst2_addr", 64'(ext_req_addr), 64'd0);
    chk("rst2_wen", 64'(ext_req_wen), 64'd0);
    chk("rst2_strb", 64'(ext_req_strb), 64'd0);
    chk("rst2_wdata", ext_req_wdata, 64'd0);
    chk("rst2_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge g_clk); #1;
      ext_rsp_valid = (i == 0);
      ext_rsp_rdata = 64'h5757;
      @(negedge g_clk);
      chk("stray_gnt", 64'(emem_gnt), 64'd0);
      chk("stray_busy", 64'(busy), 64'd0);
    end
    ext_rsp_valid = 1'b0;

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      dr = ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(0, 5));
      ds = ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(0, 5));
      rd = {$urandom, $urandom};
      txn(AW'({$urandom, $urandom}), 1'($urandom), 8'($urandom), {$urandom, $urandom},
          dr, ds, 1'($urandom_range(0, 3) == 0), rd, 1'($urandom));
      if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(3);
    chk("sb_empty", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

endmodule
